// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues PC fetches to imem, queues in-order responses, feeds decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue holds nothing filled.
//
// state | meaning
// RUN   | issue fetches, fill pending entries, present head to decode
// DRAIN | discard responses still owed for flushed requests
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          pc,
    output logic                     pc_advance,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [XLEN-1:0]          imem_resp_data,
    input  logic                     flush,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          dec_instr,
    output logic [XLEN-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    head_q, tail_q, fill_q;
    logic [OW-1:0]    occ_q, outst_q, drop_q, drop_d;
    logic [DEPTH-1:0] filled_q;
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic             run, alloc, fill, deq, byp;

    // reset is folded in so the request and bypass paths are quiet while reset is held
    assign run            = reset && (state_q == S_RUN) && !flush;
    assign imem_req_valid = run && (occ_q < OW'(DEPTH));
    assign alloc          = imem_req_valid && imem_req_ready;
    assign pc_advance     = alloc;
    assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
    assign fill           = run && imem_resp_valid;
    assign occupancy      = occ_q;
    assign dec_pc         = pc_mem[head_q];

`ifdef FETCH_QUEUE_BYPASS_EN
    // a response can only target the head while the head is still pending
    assign byp       = fill && (fill_q == head_q) && (occ_q != '0);
    assign dec_valid = filled_q[head_q] || byp;
    assign dec_instr = byp ? imem_resp_data : instr_mem[head_q];
`else
    assign byp       = 1'b0;
    assign dec_valid = filled_q[head_q];
    assign dec_instr = instr_mem[head_q];
`endif

    assign deq = dec_valid && dec_ready;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        if (flush) begin
            drop_d  = outst_q - OW'(imem_resp_valid);
            state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
        end else begin
            case (state_q)
                S_RUN: state_d = S_RUN;
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        drop_d = drop_q - OW'(1);
                        if (drop_q == OW'(1)) state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            drop_q  <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            outst_q <= outst_q + OW'(alloc) - OW'(imem_resp_valid);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            occ_q    <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            occ_q    <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) begin
                pc_mem[tail_q] <= pc;
                tail_q         <= tail_q + AW'(1);
            end
            if (fill) begin
                instr_mem[fill_q] <= imem_resp_data;
                fill_q            <= fill_q + AW'(1);
                // a bypassed entry taken by decode this cycle is never marked filled
                if (!(byp && dec_ready)) filled_q[fill_q] <= 1'b1;
            end
            if (deq) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + AW'(1);
            end
            occ_q <= occ_q + OW'(alloc) - OW'(deq);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with configurable latency,
// PC model driven by pc_advance, decode-order scoreboard.
module tb_fetch_queue;
    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_advance;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  occupancy;

    fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_advance(pc_advance),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .flush(flush), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int FIRST_LAT = 1;
    localparam int BYP_EXTRA = 1;
`else
    localparam int FIRST_LAT = 2;
    localparam int BYP_EXTRA = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          last_due, n_deq, n_acc, first_req, first_dv, mem_lat;
    bit          req_rdy_val, dec_rdy_val, req_rand, dec_rand, lat_rand, flush_now;
    logic [31:0] pc_nxt, exp_pc, new_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a & ~32'h3) ^ 32'hA5A5_0013;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        int lat, due;
        @(posedge clk);
        cyc++;
        #1;
        pc             = pc_nxt;
        flush          = flush_now;
        imem_req_ready = req_rand ? 1'($urandom_range(0, 1)) : req_rdy_val;
        dec_ready      = dec_rand ? 1'($urandom_range(0, 1)) : dec_rdy_val;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        @(negedge clk);
        if (dec_valid && first_dv < 0) first_dv = cyc;
        if (imem_req_valid && imem_req_ready) begin
            check_val("req_addr", imem_req_addr, pc & ~32'h3);
            lat = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{pc & ~32'h3, due});
            n_acc++;
            if (first_req < 0) first_req = cyc;
        end
        if (imem_resp_valid) void'(mq.pop_front());
        if (dec_valid && dec_ready) begin
            check_val("dec_pc", dec_pc, exp_pc);
            check_val("dec_instr", dec_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deq++;
        end
        if (flush) begin
            pc_nxt = new_pc;
            exp_pc = new_pc;
        end else if (pc_advance) begin
            pc_nxt = pc + 32'd4;
        end
        flush_now = 1'b0;
    endtask

    task automatic apply_reset(input logic [31:0] base);
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0; flush_now = 1'b0;
        imem_req_ready = 1'b0; dec_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        req_rdy_val = 1'b0; dec_rdy_val = 1'b0;
        req_rand = 1'b0; dec_rand = 1'b0; lat_rand = 1'b0; mem_lat = 1;
        mq.delete(); last_due = 0; n_deq = 0; n_acc = 0; first_req = -1; first_dv = -1;
        pc = base; pc_nxt = base; exp_pc = base;
        #1;
        check_val("rst_dec_valid", 32'(dec_valid), 32'd0);
        check_val("rst_dec_instr", dec_instr, 32'h0);
        check_val("rst_dec_pc", dec_pc, 32'h0);
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pc = 32'h0; flush = 1'b0; imem_req_ready = 1'b0;
        dec_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        new_pc = 32'h0;

        // streaming with single-cycle memory
        apply_reset(32'h100);
        req_rdy_val = 1'b1; dec_rdy_val = 1'b1; mem_lat = 1;
        repeat (6) tick();
        check_val("t1_advances", 32'(n_acc), 32'd6);
        check_val("t1_first_lat", 32'(first_dv - first_req), 32'(FIRST_LAT));
        check_val("t1_deq_cnt", 32'(n_deq), 32'(4 + BYP_EXTRA));

        // decode stalled: queue fills to DEPTH and stops requesting
        apply_reset(32'h100);
        req_rdy_val = 1'b1; dec_rdy_val = 1'b0; mem_lat = 1;
        repeat (6) tick();
        check_val("t2_req_cnt", 32'(n_acc), 32'd4);
        check_val("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("t2_occupancy", 32'(occupancy), 32'd4);
        check_val("t2_dec_valid", 32'(dec_valid), 32'd1);
        repeat (2) tick();
        check_val("t2_hold_pc", dec_pc, 32'h100);
        check_val("t2_hold_instr", dec_instr, instr_of(32'h100));
        dec_rdy_val = 1'b1;
        tick();
        check_val("t2_full_noreq", 32'(imem_req_valid), 32'd0);
        check_val("t2_deq_cnt", 32'(n_deq), 32'd1);
        tick();
        check_val("t2_fifth_adv", 32'(pc_advance), 32'd1);
        check_val("t2_fifth_addr", imem_req_addr, 32'h110);

        // flush with two requests in flight on a 3-cycle memory
        apply_reset(32'h100);
        req_rdy_val = 1'b1; dec_rdy_val = 1'b1; mem_lat = 3;
        repeat (2) tick();
        req_rdy_val = 1'b0; flush_now = 1'b1; new_pc = 32'h200;
        tick();
        check_val("t3_flush_noreq", 32'(imem_req_valid), 32'd0);
        req_rdy_val = 1'b1;
        tick();
        check_val("t3_dec_valid", 32'(dec_valid), 32'd0);
        check_val("t3_occupancy", 32'(occupancy), 32'd0);
        check_val("t3_drain_req1", 32'(imem_req_valid), 32'd0);
        tick();
        check_val("t3_drain_req2", 32'(imem_req_valid), 32'd0);
        check_val("t3_drain_dv", 32'(dec_valid), 32'd0);
        tick();
        check_val("t3_run_adv", 32'(pc_advance), 32'd1);
        check_val("t3_run_addr", imem_req_addr, 32'h200);
        for (int i = 0; i < 30 && n_deq < 1; i++) tick();
        check_val("t3_new_stream", 32'(n_deq >= 1), 32'd1);

        // flush coincident with the only outstanding response
        apply_reset(32'h100);
        req_rdy_val = 1'b1; dec_rdy_val = 1'b1; mem_lat = 2;
        tick();
        req_rdy_val = 1'b0;
        tick();
        req_rdy_val = 1'b1; flush_now = 1'b1; new_pc = 32'h200;
        tick();
        check_val("t4_flush_resp", 32'(imem_resp_valid), 32'd1);
        check_val("t4_flush_noreq", 32'(imem_req_valid), 32'd0);
        tick();
        check_val("t4_run_adv", 32'(pc_advance), 32'd1);
        check_val("t4_run_addr", imem_req_addr, 32'h200);
        check_val("t4_dec_valid", 32'(dec_valid), 32'd0);
        check_val("t4_occupancy", 32'(occupancy), 32'd0);
        for (int i = 0; i < 30 && n_deq < 1; i++) tick();
        check_val("t4_new_stream", 32'(n_deq >= 1), 32'd1);

        // asynchronous reset with three filled entries
        apply_reset(32'h100);
        req_rdy_val = 1'b1; dec_rdy_val = 1'b0; mem_lat = 1;
        repeat (3) tick();
        req_rdy_val = 1'b0;
        tick();
        check_val("t5_pre_occ", 32'(occupancy), 32'd3);
        check_val("t5_pre_dv", 32'(dec_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("t5_async_dv", 32'(dec_valid), 32'd0);
        check_val("t5_async_occ", 32'(occupancy), 32'd0);
        check_val("t5_async_req", 32'(imem_req_valid), 32'd0);
        apply_reset(32'h300);
        req_rdy_val = 1'b1; dec_rdy_val = 1'b1; mem_lat = 1;
        repeat (8) tick();
        check_val("t5_resume_cnt", 32'(n_deq), 32'(6 + BYP_EXTRA));

        // wrap-around under random backpressure and latency, unaligned pc
        apply_reset(32'h402);
        req_rand = 1'b1; dec_rand = 1'b1; lat_rand = 1'b1;
        for (int i = 0; i < 800 && n_deq < 20; i++) tick();
        check_val("t6_wrap_cnt", 32'(n_deq >= 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of program_counter.
- Issues word fetches for the current PC to instruction memory over a valid/ready request channel and accepts in-order responses with variable latency.
- Buffers fetched instructions with their PCs in a DEPTH-entry queue and presents them to decode over a valid/ready handshake.
- Drives pc_advance back to the pc_next selection, and supports flush on branch/jump redirect.

Parameters:
XLEN, 32, PC and instruction width.
DEPTH, 4, queue entries; power of two, >= 2.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
pc  input  XLEN  current PC from program_counter.
pc_advance  output  1  request accepted this cycle; pc_next selects pc+4 when high, else holds pc.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  XLEN  {pc[XLEN-1:2],2'b00}.
imem_resp_valid  input  1  response valid; in order, never before its request.
imem_resp_data  input  XLEN  fetched instruction.
flush  input  1  redirect: discard queue and in-flight fetches.
dec_valid  output  1  head entry holds a valid instruction.
dec_ready  input  1  decode consumes head.
dec_instr  output  XLEN  head instruction.
dec_pc  output  XLEN  PC of head instruction.
occupancy  output  $clog2(DEPTH)+1  allocated entries (filled + pending).

Behaviour:
- Reset (reset=0, asynchronous):
  - Head/tail/fill pointers, occupancy, outstanding and drop counters clear to 0.
  - FSM goes to RUN.
  - dec_valid=0, dec_instr=0, dec_pc=0, imem_req_valid=0.
  - The first request may assert in the first cycle after release.
- Entry allocation at request acceptance:
  - imem_req_valid = (occupancy < DEPTH) & !flush & (state==RUN).
  - Occupancy is taken before any same-cycle dequeue (conservative: no alloc+dequeue when full).
  - On imem_req_valid & imem_req_ready: write pc into the tail entry marked pending, advance tail, pulse pc_advance=1.
  - pc_advance is exactly that handshake, combinational.
- Response:
  - On imem_resp_valid in RUN: write imem_resp_data to the oldest pending entry and mark it filled.
  - Responses fill entries strictly in allocation order.
- Dequeue:
  - dec_valid = head entry filled. dec_instr/dec_pc are registered from the head entry.
  - On dec_valid & dec_ready: free the head and advance it.
  - dec_instr/dec_pc hold stable while dec_valid & !dec_ready.
- Latency: response in cycle N -> dec_valid in cycle N+1 when the queue is otherwise empty.
- Simultaneous events: allocate, fill and dequeue in the same cycle on distinct entries are all legal. occupancy += alloc - dequeue.
- Pointer wrap-around: modulo DEPTH. The full/empty distinction comes from occupancy.
- FSM states:
  - RUN: normal operation.
  - DRAIN: discarding responses to flushed requests.
- flush (highest priority, any state):
  - Next cycle: all entries invalid, pointers and occupancy 0, dec_valid=0.
  - No request is issued in the flush cycle.
  - drop_cnt <= outstanding requests (accepted, not yet responded), minus 1 if imem_resp_valid is high in the flush cycle. That response is discarded.
  - Next state = DRAIN if drop_cnt>0, else RUN.
- DRAIN:
  - imem_req_valid=0.
  - Each imem_resp_valid decrements drop_cnt; data is discarded.
  - At 0 -> RUN.
  - A further flush in DRAIN keeps the count (no new requests were issued).
- Outstanding counter:
  - +1 on request acceptance, -1 on response.
  - Never exceeds DEPTH.
- PC alignment: pc[1:0] ignored; dec_pc carries the full pc as received.

Optional Feature:
Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When the queue has no filled entries and the response targets the head entry, dec_valid=1 in the same cycle as imem_resp_valid.
  - dec_instr=imem_resp_data and dec_pc=head pc, combinationally.
  - If dec_ready is also high, the entry is freed without ever being stored as filled.
  - Zero-cycle latency.
- Undefined: all outputs come from queue storage; latency 1 cycle as above.

Test Plan:
- Reset release, pc=0x100, imem_req_ready=1, 1-cycle memory, dec_ready=1 -> pc_advance each cycle; dec_pc sequence 0x100,0x104,0x108 with matching instr; first dec_valid 2 cycles after first request (1 with bypass).
- dec_ready=0, memory always ready -> exactly DEPTH=4 requests; imem_req_valid=0 and occupancy=4; dec_pc stable at 0x100; on dec_ready=1 the fifth request issues the cycle after the first dequeue.
- Memory latency 3 cycles with 2 outstanding, flush asserted -> next cycle dec_valid=0, occupancy=0; next 2 responses dropped; no request until DRAIN exits; following fetch of new pc=0x200 appears as dec_pc=0x200.
- flush coincident with imem_resp_valid and 1 outstanding -> that response dropped, drop_cnt=0, RUN next cycle, request issued immediately.
- reset pulsed low mid-stream with 3 entries filled -> asynchronously dec_valid=0, occupancy=0, imem_req_valid=0; fetch resumes cleanly after release.
- Wrap-around: stream 20 instructions through DEPTH=4 with random dec_ready/imem_req_ready -> dec_pc strictly increments by 4, no loss/duplication.
